// File: rtl/wrapper_packet_arbiter.sv
// Round-robin arbiter sharing one registered packet output between NUM_REQ
// packet sources; a grant is held from the first beat through the last beat.
module wrapper_packet_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int PACKETWIDTH = 512,
  parameter int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           hclk,
  input  logic                           hreset,
  input  logic [NUM_REQ*PACKETWIDTH-1:0] req_packet_data,
  input  logic [NUM_REQ-1:0]             req_packet_data_last,
  input  logic [NUM_REQ-1:0]             req_packet_data_valid,
  output logic [NUM_REQ-1:0]             req_packet_data_ready,
  output logic [PACKETWIDTH-1:0]         packet_data,
  output logic                           packet_data_last,
  output logic                           packet_data_valid,
  input  logic                           packet_data_ready,
  output logic [IDW-1:0]                 grant_id,
  output logic                           grant_active
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t state, state_nxt;

  logic [IDW-1:0]         rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0]         grant_nxt;
  logic [IDW-1:0]         pick;
  logic [IDW-1:0]         cand;
  logic                   pick_found;
  logic                   slot_free;
  logic                   accept;
  logic [PACKETWIDTH-1:0] sel_data;
  logic                   sel_last;
  logic                   sel_valid;

  // First valid requester after rr_ptr, wrapping; the last winner is searched last.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((32'(rr_ptr) + k) % NUM_REQ);
      if (!pick_found && req_packet_data_valid[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_data  = req_packet_data[i*PACKETWIDTH +: PACKETWIDTH];
        sel_last  = req_packet_data_last[i];
        sel_valid = req_packet_data_valid[i];
      end
    end
  end

  assign slot_free = !packet_data_valid || packet_data_ready;
  assign accept    = (state == LOCKED) && sel_valid && slot_free;

  always_comb begin
    req_packet_data_ready = '0;
    if (state == LOCKED) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant_id == IDW'(i)) req_packet_data_ready[i] = slot_free;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_id;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt = pick;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && sel_last) begin
          rr_ptr_nxt = grant_id;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state    <= IDLE;
      rr_ptr   <= IDW'(NUM_REQ - 1);
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_id <= grant_nxt;
    end
  end

  // Output slice reloads on the same cycle it drains, giving one beat per cycle.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      packet_data       <= '0;
      packet_data_last  <= 1'b0;
      packet_data_valid <= 1'b0;
    end else if (accept) begin
      packet_data       <= sel_data;
      packet_data_last  <= sel_last;
      packet_data_valid <= 1'b1;
    end else if (packet_data_ready) begin
      packet_data_valid <= 1'b0;
    end
  end

  assign grant_active = (state == LOCKED);

endmodule

// File: tb/tb_wrapper_packet_arbiter.sv
// Self-checking bench for wrapper_packet_arbiter: vector table, directed corner
// sequences, and randomized message streams checked against a message-level model.
module tb_wrapper_packet_arbiter;

  localparam int NR = 4;
  localparam int PW = 16;
  localparam int IW = 2;

  logic             hclk = 1'b0;
  logic             hreset = 1'b1;
  logic [NR*PW-1:0] req_data = '0;
  logic [NR-1:0]    req_last = '0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [PW-1:0]    pd;
  logic             pd_last;
  logic             pd_valid;
  logic             pd_ready = 1'b0;
  logic [IW-1:0]    gid;
  logic             gact;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 hclk = ~hclk;

  wrapper_packet_arbiter #(
    .NUM_REQ    (NR),
    .PACKETWIDTH(PW)
  ) dut (
    .hclk                 (hclk),
    .hreset               (hreset),
    .req_packet_data      (req_data),
    .req_packet_data_last (req_last),
    .req_packet_data_valid(req_valid),
    .req_packet_data_ready(req_ready),
    .packet_data          (pd),
    .packet_data_last     (pd_last),
    .packet_data_valid    (pd_valid),
    .packet_data_ready    (pd_ready),
    .grant_id             (gid),
    .grant_active         (gact)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [PW-1:0] d, input logic l);
    req_valid[0]   = v;
    req_data[PW-1:0] = d;
    req_last[0]    = l;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
  endtask

  // ---------------- message-level reference model ----------------
  logic [PW:0] beatq [NR][$];  // driver side: {last,data} per requester
  logic [PW:0] mq    [NR][$];  // model copy of the same beats
  int          msgs  [NR][$];  // message lengths per requester
  int          model_rr = NR - 1;
  int          last_obs [$];

  task automatic add_msg(input int r, input int len);
    logic [PW-1:0] d;
    for (int b = 0; b < len; b++) begin
      d = PW'($urandom);
      d[PW-1 -: 2] = IW'(r);
      beatq[r].push_back({(b == len - 1) ? 1'b1 : 1'b0, d});
      mq[r].push_back({(b == len - 1) ? 1'b1 : 1'b0, d});
    end
    msgs[r].push_back(len);
  endtask

  task automatic do_reset();
    @(posedge hclk);
    #1;
    hreset = 1'b1;
    clear_inputs();
    for (int j = 0; j < NR; j++) begin
      beatq[j].delete();
      mq[j].delete();
      msgs[j].delete();
    end
    repeat (2) @(posedge hclk);
    #1;
    hreset = 1'b0;
    model_rr = NR - 1;
  endtask

  task automatic run_stream(input int pdr_pct);
    logic [PW:0] expq [$];
    int          exp_order [$];
    logic        prev_gact;
    logic        hold;
    logic [PW:0] held;
    int          cyc;
    int          c;
    int          len;
    bit          found;
    bit          pending;
    // message order from the round-robin rule applied to queued messages
    forever begin
      found = 0;
      c = 0;
      for (int k = 1; k <= NR; k++) begin
        if (!found && msgs[(model_rr + k) % NR].size() > 0) begin
          c = (model_rr + k) % NR;
          found = 1;
        end
      end
      if (!found) break;
      len = msgs[c].pop_front();
      for (int b = 0; b < len; b++) expq.push_back(mq[c].pop_front());
      exp_order.push_back(c);
      model_rr = c;
    end
    last_obs.delete();
    prev_gact = 1'b0;
    hold = 1'b0;
    held = '0;
    cyc = 0;
    pending = 1;
    while (pending && cyc < 3000) begin
      for (int j = 0; j < NR; j++) begin
        if (beatq[j].size() > 0) begin
          req_valid[j] = 1'b1;
          req_last[j]  = beatq[j][0][PW];
          req_data[j*PW +: PW] = beatq[j][0][PW-1:0];
        end else begin
          req_valid[j] = 1'b0;
          req_last[j]  = 1'b0;
          req_data[j*PW +: PW] = '0;
        end
      end
      pd_ready = ($urandom_range(0, 99) < pdr_pct);
      @(negedge hclk);
      if (gact && !prev_gact) last_obs.push_back(int'(gid));
      prev_gact = gact;
      for (int j = 0; j < NR; j++)
        if (req_ready[j]) check("ready_only_granted", {gact, gid}, {1'b1, IW'(j)});
      if (hold) check("held_beat_stable", {pd_valid, pd_last, pd}, {1'b1, held});
      hold = pd_valid && !pd_ready;
      held = {pd_last, pd};
      if (pd_valid && pd_ready) begin
        if (expq.size() == 0) check("extra_beat", 32'd1, 32'd0);
        else check("beat", {pd_last, pd}, expq.pop_front());
      end
      for (int j = 0; j < NR; j++)
        if (req_valid[j] && req_ready[j]) void'(beatq[j].pop_front());
      adv();
      cyc++;
      pending = (expq.size() > 0);
      for (int j = 0; j < NR; j++) if (beatq[j].size() > 0) pending = 1;
    end
    clear_inputs();
    pd_ready = 1'b1;
    check("stream_drained_in_budget", {31'd0, pending}, 32'd0);
    check("grant_count", last_obs.size(), exp_order.size());
    for (int i = 0; i < exp_order.size() && i < last_obs.size(); i++)
      check("grant_order", last_obs[i], exp_order[i]);
  endtask

  // ---------------- vector table: one 3-beat message from req0 ----------------
  typedef struct {
    logic          v;
    logic [PW-1:0] d;
    logic          l;
    logic          pdr;
    logic          e_rdy;
    logic          e_vld;
    logic [PW-1:0] e_data;
    logic          e_last;
    logic          e_gact;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 16'h00A0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 16'h00A0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 16'h00A1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00A0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 16'h00A2, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00A1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00A2, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};

    // reset state
    @(posedge hclk);
    #1;
    check("rst_pd_valid", {31'd0, pd_valid}, 32'd0);
    check("rst_pd_data", {16'd0, pd}, 32'd0);
    check("rst_pd_last", {31'd0, pd_last}, 32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_grant_active", {31'd0, gact}, 32'd0);
    check("rst_grant_id", {30'd0, gid}, 32'd0);
    do_reset();

    for (int i = 0; i < 6; i++) begin
      drive0(tbl[i].v, tbl[i].d, tbl[i].l);
      pd_ready = tbl[i].pdr;
      @(negedge hclk);
      check("tbl_req_ready0", {31'd0, req_ready[0]}, {31'd0, tbl[i].e_rdy});
      check("tbl_pd_valid", {31'd0, pd_valid}, {31'd0, tbl[i].e_vld});
      check("tbl_grant_active", {31'd0, gact}, {31'd0, tbl[i].e_gact});
      check("tbl_grant_id", {30'd0, gid}, 32'd0);
      if (tbl[i].e_vld) begin
        check("tbl_pd_data", {16'd0, pd}, {16'd0, tbl[i].e_data});
        check("tbl_pd_last", {31'd0, pd_last}, {31'd0, tbl[i].e_last});
      end
      adv();
    end

    // backpressure: output stalls 4 cycles with B0 in the slice and B1 waiting
    drive0(1'b1, 16'h00B0, 1'b0);
    pd_ready = 1'b1;
    adv();
    adv();
    drive0(1'b1, 16'h00B1, 1'b0);
    pd_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge hclk);
      check("bp_req_ready_low", {31'd0, req_ready[0]}, 32'd0);
      check("bp_hold_valid", {31'd0, pd_valid}, 32'd1);
      check("bp_hold_data", {16'd0, pd}, 32'h00B0);
      check("bp_hold_last", {31'd0, pd_last}, 32'd0);
      adv();
    end
    pd_ready = 1'b1;
    @(negedge hclk);
    check("bp_release_ready", {31'd0, req_ready[0]}, 32'd1);
    adv();
    drive0(1'b1, 16'h00B2, 1'b0);
    @(negedge hclk);
    check("bp_beat1", {15'd0, pd_valid, pd_last, pd}, {15'd0, 2'b10, 16'h00B1});
    adv();
    drive0(1'b1, 16'h00B3, 1'b1);
    @(negedge hclk);
    check("bp_beat2", {15'd0, pd_valid, pd_last, pd}, {15'd0, 2'b10, 16'h00B2});
    adv();
    drive0(1'b0, 16'h0000, 1'b0);
    @(negedge hclk);
    check("bp_beat3", {15'd0, pd_valid, pd_last, pd}, {15'd0, 2'b11, 16'h00B3});
    adv();
    @(negedge hclk);
    check("bp_drained", {30'd0, pd_valid, gact}, 32'd0);
    adv();

    // two requesters, continuously valid, 2-beat messages, full throughput
    do_reset();
    for (int m = 0; m < 3; m++) begin
      add_msg(0, 2);
      add_msg(1, 2);
    end
    run_stream(100);

    // rr_ptr left at 1: requests on 1 and 3 go to 3 first, then 1
    add_msg(1, 1);
    run_stream(100);
    add_msg(1, 2);
    add_msg(3, 2);
    run_stream(100);
    check("rr_skip_count", last_obs.size(), 2);
    if (last_obs.size() == 2) begin
      check("rr_skip_first", last_obs[0], 3);
      check("rr_skip_second", last_obs[1], 1);
    end

    // randomized message mixes with random output backpressure
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < NR; j++) begin
        int n;
        n = $urandom_range(0, 3);
        for (int m = 0; m < n; m++) add_msg(j, $urandom_range(1, 4));
      end
      run_stream(60);
    end

    // reset during beat 2 of a 4-beat message from req2
    req_valid[2] = 1'b1;
    req_data[2*PW +: PW] = 16'h00C0;
    req_last[2] = 1'b0;
    pd_ready = 1'b1;
    adv();
    adv();
    req_data[2*PW +: PW] = 16'h00C1;
    @(negedge hclk);
    check("mid_pre_grant", {30'd0, gid}, 32'd2);
    check("mid_pre_valid", {31'd0, pd_valid}, 32'd1);
    hreset = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, pd_valid}, 32'd0);
    check("mid_rst_data", {16'd0, pd}, 32'd0);
    check("mid_rst_last", {31'd0, pd_last}, 32'd0);
    check("mid_rst_ready", {28'd0, req_ready}, 32'd0);
    check("mid_rst_gact", {31'd0, gact}, 32'd0);
    check("mid_rst_gid", {30'd0, gid}, 32'd0);
    clear_inputs();
    adv();
    hreset = 1'b0;
    model_rr = NR - 1;
    for (int j = 0; j < NR; j++) add_msg(j, 1);
    run_stream(100);
    if (last_obs.size() > 0) check("post_rst_first_grant", last_obs[0], 0);
    else check("post_rst_any_grant", 32'd0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wrapper_packet_arbiter.md
Name: wrapper_packet_arbiter

Overview:
- Round-robin arbiter that shares one accelerator packet input (valid/ready/last) between NUM_REQ packet-construction sources (e.g. several register-write packet constructors).
- Grant is held for a whole message, from the first beat to the beat with last=1, so messages never interleave.
- Output stage is a single registered slice in front of the accelerator input.

Parameters:
- NUM_REQ, 2, number of requesting packet streams (2..8).
- PACKETWIDTH, 512, packet data width in bits.
- IDW, $clog2(NUM_REQ) (minimum 1), width of the grant index.

Ports:
- hclk  input  1  clock.
- hreset  input  1  reset; asynchronous, active-high.
- req_packet_data  input  NUM_REQ*PACKETWIDTH  request data; requester i occupies bits [i*PACKETWIDTH +: PACKETWIDTH].
- req_packet_data_last  input  NUM_REQ  last-beat flag per requester.
- req_packet_data_valid  input  NUM_REQ  valid per requester.
- req_packet_data_ready  output  NUM_REQ  ready per requester.
- packet_data  output  PACKETWIDTH  arbitrated packet to the accelerator.
- packet_data_last  output  1  last beat of a message.
- packet_data_valid  output  1  output valid.
- packet_data_ready  input  1  accelerator ready.
- grant_id  output  IDW  index of the current or most recent grant.
- grant_active  output  1  high while in LOCKED.

Behaviour:
- Reset (asynchronous on hreset=1):
  - state=IDLE; rr_ptr=NUM_REQ-1; grant_id=0; grant_active=0.
  - packet_data=0, packet_data_last=0, packet_data_valid=0.
  - All req_packet_data_ready=0.
  - A reset mid-message drops the partial message; no resume.
- FSM IDLE:
  - If any req_packet_data_valid is set, pick the first valid index searching (rr_ptr+1) mod NUM_REQ upward with wrap.
  - Register that index into grant_id and go to LOCKED.
  - No ready is asserted in IDLE, so arbitration costs one cycle.
- FSM LOCKED:
  - req_packet_data_ready[grant_id] = (!packet_data_valid || packet_data_ready). This is combinational.
  - All other ready bits are 0.
  - Beat accept = ready && valid of the granted requester.
  - On accept, load that requester's data and last into the output register and set packet_data_valid=1 the next cycle. Latency is 1 cycle.
  - On accept with last=1: rr_ptr<=grant_id, go to IDLE; grant_id holds its value.
- Output slice:
  - If packet_data_valid && packet_data_ready with no new accept, clear packet_data_valid.
  - If a new accept happens in the same cycle, the slice reloads and stays valid. This gives full throughput, one beat per cycle in LOCKED.
  - packet_data and packet_data_last are stable while valid && !ready.
- Fairness:
  - A requester granted a message gets lowest priority for the next arbitration.
  - With all NUM_REQ valid continuously, grants rotate 0,1,...,NUM_REQ-1,0.
- Valid withdrawn mid-message by the granted requester: the arbiter stays LOCKED and waits. A requester must not drop valid without a handshake.
- Other requesters' valid is ignored in LOCKED and sampled only in IDLE.
- Single requester: it is re-granted after a one-cycle IDLE bubble between messages.
- grant_active=1 exactly when state==LOCKED.

Test Plan:
- Reset, then req0 sends a 3-beat message (data 0xA0,0xA1,0xA2; last on beat 3) with packet_data_ready=1 → grant_id=0, outputs 0xA0..0xA2 on consecutive cycles starting 1 cycle after each accept, packet_data_last on 0xA2 only, then IDLE.
- req0 and req1 both valid with 2-beat messages, continuously refilled → message order req0, req1, req0, req1; no interleaving; one-cycle bubble between messages.
- Backpressure: packet_data_ready=0 for 4 cycles mid-message → req ready drops, packet_data and packet_data_last stay held; on release, the next beat follows with no loss or duplication.
- NUM_REQ=4, requests on 1 and 3 only, rr_ptr=1 → grant 3 first, then 1.
- Assert hreset during beat 2 of a 4-beat message → all outputs 0 immediately, state IDLE, rr_ptr=NUM_REQ-1; after release, req0 is granted first when all requesters are valid.
